// File: rtl/io_bus_controller_if.sv
// rtl/io_bus_controller_if.sv - CPU-side and device-side signal bundle for io_bus_controller
//
// Purpose: groups the CPU IO port and the peripheral select/data bus of the
// IO space sequencer into one interface.
//   master modport : the controller view (drives acks, selects, device data)
//   slave modport  : the environment view (CPU core plus peripherals)
// Signals:
//   CpuReq/CpuWrite/CpuAddr/CpuWrData  CPU access strobe and its qualifiers
//   CpuRdData/CpuAck/CpuErr/Busy       completion back to the CPU
//   DevSel/DevWrite/DevRegAddr/DevWrData  one-hot slot select and access fields
//   DevRdData/DevReady                 per-slot read data (packed) and completion
interface io_bus_controller_if #(
  parameter int DATA_W = 32
);
  logic                CpuReq;
  logic                CpuWrite;
  logic [6:0]          CpuAddr;
  logic [DATA_W-1:0]   CpuWrData;
  logic [DATA_W-1:0]   CpuRdData;
  logic                CpuAck;
  logic                CpuErr;
  logic                Busy;
  logic [7:0]          DevSel;
  logic                DevWrite;
  logic [3:0]          DevRegAddr;
  logic [DATA_W-1:0]   DevWrData;
  logic [8*DATA_W-1:0] DevRdData;
  logic [7:0]          DevReady;

  modport master (
    input  CpuReq, CpuWrite, CpuAddr, CpuWrData, DevRdData, DevReady,
    output CpuRdData, CpuAck, CpuErr, Busy, DevSel, DevWrite, DevRegAddr, DevWrData
  );

  modport slave (
    output CpuReq, CpuWrite, CpuAddr, CpuWrData, DevRdData, DevReady,
    input  CpuRdData, CpuAck, CpuErr, Busy, DevSel, DevWrite, DevRegAddr, DevWrData
  );
endinterface

// File: rtl/io_bus_controller.sv
// rtl/io_bus_controller.sv - sequencer for CPU accesses to the 8-slot IO space
//
// Purpose: decodes IO address {Dev[2:0], Reg[3:0]}, selects the addressed slot
// one-hot, waits for that slot's ready and returns data/ack/error to the CPU.
// Reserved slots (clear bits in DEV_PRESENT) complete immediately with an error.
// One access in flight; requests arriving while busy are dropped.
// Ports:
//   Clock    system clock, rising edge
//   Reset_N  asynchronous active-low reset
//   bus      io_bus_controller_if.master (CPU port and device bus)
// Optional feature: define IO_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT
// cycles, after which the access ends with a bus error.
module io_bus_controller #(
  parameter int          DATA_W      = 32,
  parameter logic [7:0]  DEV_PRESENT = 8'b0000_0011,
  parameter int          TIMEOUT     = 15
) (
  input  logic              Clock,
  input  logic              Reset_N,
  io_bus_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_e;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("io_bus_controller: TIMEOUT must be within 1..255");
  end

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        dev_q, dev_d;
  logic [3:0]        reg_q, reg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef IO_TIMEOUT_EN
  // Last count value seen without ready before giving up; the ACCESS state
  // therefore lasts at most TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]        wait_q, wait_d;
`endif

  // Only the selected slot's ready and read data matter.
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  assign sel_ready = bus.DevReady[dev_q];
  assign sel_rdata = bus.DevRdData[dev_q*DATA_W +: DATA_W];

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      dev_q   <= 3'd0;
      reg_q   <= 4'd0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef IO_TIMEOUT_EN
      wait_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef IO_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef IO_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.CpuReq) begin
          write_d = bus.CpuWrite;
          dev_d   = bus.CpuAddr[6:4];
          reg_d   = bus.CpuAddr[3:0];
          wdata_d = bus.CpuWrData;
          if (DEV_PRESENT[bus.CpuAddr[6:4]]) begin
            state_d = ACCESS;
`ifdef IO_TIMEOUT_EN
            wait_d  = 8'd0;
`endif
          end else begin
            // Read data is zeroed so it reads 0 in the error-ack cycle.
            state_d = ERR;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          if (!write_q) begin
            rdata_d = sel_rdata;
          end
          state_d = DONE;
        end
`ifdef IO_TIMEOUT_EN
        // Ready takes priority over the timeout in the same cycle.
        else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
          rdata_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_access;
  assign in_access      = (state_q == ACCESS);

  assign bus.Busy       = (state_q != IDLE);
  assign bus.CpuAck     = (state_q == DONE) || (state_q == ERR);
  assign bus.CpuErr     = (state_q == ERR);
  assign bus.CpuRdData  = rdata_q;
  assign bus.DevSel     = in_access ? (8'd1 << dev_q) : 8'd0;
  assign bus.DevWrite   = in_access & write_q;
  assign bus.DevRegAddr = in_access ? reg_q : 4'd0;
  assign bus.DevWrData  = in_access ? wdata_q : '0;

endmodule
